// File: rtl/tx_serializer.sv
// TX-side parallel-to-serial converter: one DATA_WIDTH-bit frame per DATA_WIDTH clocks, LSB first.
// Sources per frame: payload (valid/ready), PRBS7 training, 1010 clock pattern or hold-low.
module tx_serializer #(
    parameter int unsigned           DATA_WIDTH   = 10,
    parameter logic [DATA_WIDTH-1:0] IDLE_PATTERN = 10'b0101010101,
    parameter logic [6:0]            PRBS_SEED    = 7'h7F
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic [1:0]            mode,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  data_valid,
    output logic                  data_ready,
    output logic                  serial_out,
    output logic                  word_start,
    output logic                  underflow
);

    localparam int unsigned   CW       = $clog2(DATA_WIDTH);
    localparam logic [CW-1:0] LAST_BIT = CW'(DATA_WIDTH - 1);

    localparam logic [0:0] ST_OFF = 1'b0;
    localparam logic [0:0] ST_RUN = 1'b1;

    localparam logic [1:0] MODE_DATA = 2'b00;
    localparam logic [1:0] MODE_PRBS = 2'b01;
    localparam logic [1:0] MODE_CLK  = 2'b10;

    logic [0:0]            state_q,     state_d;
    logic [CW-1:0]         bit_cnt_q,   bit_cnt_d;
    logic [DATA_WIDTH-1:0] shreg_q,     shreg_d;
    logic [6:0]            lfsr_q,      lfsr_d;
    logic [1:0]            last_mode_q, last_mode_d;
    logic                  serial_q,    serial_d;
    logic                  word_start_q, word_start_d;
    logic                  underflow_q, underflow_d;

    logic                  load_slot;
    logic [CW-1:0]         bit_nxt;
    logic [6:0]            lfsr_walk;
    logic [DATA_WIDTH-1:0] prbs_word;
    logic [DATA_WIDTH-1:0] clk_word;
    logic [DATA_WIDTH-1:0] word;

    assign load_slot  = en & ((state_q == ST_OFF) | (bit_cnt_q == LAST_BIT));
    assign data_ready = load_slot & (mode == MODE_DATA) & ~rst;
    assign bit_nxt    = bit_cnt_q + CW'(1);

    assign serial_out = serial_q;
    assign word_start = word_start_q;
    assign underflow  = underflow_q;

    // PRBS7 restarts from the seed whenever the link enters PRBS mode afresh; otherwise it continues.
    always_comb begin
        lfsr_walk = ((state_q == ST_OFF) || (last_mode_q != MODE_PRBS)) ? PRBS_SEED : lfsr_q;
        prbs_word = '0;
        clk_word  = '0;
        for (int unsigned i = 0; i < DATA_WIDTH; i++) begin
            prbs_word[i] = lfsr_walk[6];
            lfsr_walk    = {lfsr_walk[5:0], lfsr_walk[6] ^ lfsr_walk[5]};
            clk_word[i]  = ~i[0];
        end
    end

    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        shreg_d      = shreg_q;
        lfsr_d       = lfsr_q;
        last_mode_d  = last_mode_q;
        serial_d     = 1'b0;
        word_start_d = 1'b0;
        underflow_d  = 1'b0;
        word         = '0;

        if (!en) begin
            state_d   = ST_OFF;
            bit_cnt_d = '0;
        end else if (load_slot) begin
            state_d      = ST_RUN;
            last_mode_d  = mode;
            bit_cnt_d    = '0;
            word_start_d = 1'b1;
            case (mode)
                MODE_DATA: begin
                    if (data_valid) begin
                        word = data_in;
                    end else begin
                        word        = IDLE_PATTERN;
                        underflow_d = 1'b1;
                    end
                end
                MODE_PRBS: begin
                    word   = prbs_word;
                    lfsr_d = lfsr_walk;
                end
                MODE_CLK: word = clk_word;
                default:  word = '0;
            endcase
            shreg_d  = word;
            serial_d = word[0];
        end else begin
            serial_d  = shreg_q[bit_nxt];
            bit_cnt_d = bit_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_OFF;
            bit_cnt_q    <= '0;
            shreg_q      <= '0;
            lfsr_q       <= PRBS_SEED;
            last_mode_q  <= MODE_DATA;
            serial_q     <= 1'b0;
            word_start_q <= 1'b0;
            underflow_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            shreg_q      <= shreg_d;
            lfsr_q       <= lfsr_d;
            last_mode_q  <= last_mode_d;
            serial_q     <= serial_d;
            word_start_q <= word_start_d;
            underflow_q  <= underflow_d;
        end
    end

endmodule

// File: tb/tb_tx_serializer.sv
// Directed plus randomized bench for tx_serializer against a frame-level reference model.
module tb_tx_serializer;

    localparam int unsigned W    = 10;
    localparam logic [W-1:0] IDLE = 10'b0101010101;
    localparam logic [6:0]   SEED = 7'h7F;

    logic         clk = 1'b0;
    logic         rst;
    logic         en;
    logic [1:0]   mode;
    logic [W-1:0] data_in;
    logic         data_valid;
    logic         data_ready;
    logic         serial_out;
    logic         word_start;
    logic         underflow;

    int unsigned  checks = 0;
    int unsigned  errors = 0;

    // Reference model state
    bit           m_run;
    int           m_pos;
    logic [W-1:0] m_word;
    logic [6:0]   m_lfsr;
    logic [1:0]   m_last;
    logic         e_ser, e_ws, e_uf;

    logic         obs[$];
    int           xfers;
    int           uf_cnt;

    tx_serializer #(
        .DATA_WIDTH  (W),
        .IDLE_PATTERN(IDLE),
        .PRBS_SEED   (SEED)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .mode      (mode),
        .data_in   (data_in),
        .data_valid(data_valid),
        .data_ready(data_ready),
        .serial_out(serial_out),
        .word_start(word_start),
        .underflow (underflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Called at posedge+1 with inputs already driven; returns at the next posedge+1.
    task automatic tick();
        logic         ls, er;
        logic [W-1:0] w;
        #1;
        ls = en && (!m_run || m_pos == W - 1);
        er = ls && (mode == 2'b00) && !rst;
        chk("data_ready", data_ready, er);
        if (er && data_valid) xfers++;
        w = '0;
        if (rst) begin
            m_run = 0; m_pos = 0; m_lfsr = SEED; m_last = 2'b00;
            e_ser = 0; e_ws = 0; e_uf = 0;
        end else if (!en) begin
            m_run = 0; m_pos = 0;
            e_ser = 0; e_ws = 0; e_uf = 0;
        end else if (ls) begin
            e_uf = 0;
            case (mode)
                2'b00: begin
                    if (data_valid) w = data_in;
                    else begin w = IDLE; e_uf = 1; end
                end
                2'b01: begin
                    if (!m_run || m_last != 2'b01) m_lfsr = SEED;
                    for (int i = 0; i < W; i++) begin
                        w[i]   = m_lfsr[6];
                        m_lfsr = {m_lfsr[5:0], m_lfsr[6] ^ m_lfsr[5]};
                    end
                end
                2'b10: for (int i = 0; i < W; i++) w[i] = (i % 2 == 0);
                default: w = '0;
            endcase
            m_last = mode; m_word = w; m_pos = 0; m_run = 1;
            e_ser = w[0]; e_ws = 1;
        end else begin
            m_pos++;
            e_ser = m_word[m_pos]; e_ws = 0; e_uf = 0;
        end
        @(posedge clk);
        #1;
        chk("serial_out", serial_out, e_ser);
        chk("word_start", word_start, e_ws);
        chk("underflow", underflow, e_uf);
        obs.push_back(serial_out);
        if (underflow) uf_cnt++;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        logic [W-1:0] t1_word;
        logic [13:0]  prbs14;
        int           run0, max_run0;

        t1_word = 10'h2C5;
        prbs14  = 14'b1_000000_1111111;
        m_run = 0; m_pos = 0; m_word = '0; m_lfsr = SEED; m_last = 2'b00;
        e_ser = 0; e_ws = 0; e_uf = 0; xfers = 0; uf_cnt = 0;

        rst = 1; en = 1; mode = 2'b00; data_in = t1_word; data_valid = 1;
        @(posedge clk);
        #1;
        ticks(2);
        chk("reset_serial", serial_out, 1'b0);

        // 1: single word, LSB first
        rst = 0;
        obs.delete();
        tick();
        data_valid = 0;
        ticks(W - 1);
        for (int i = 0; i < W; i++) chk("t1_bit", obs[i], t1_word[i]);

        // 2: back-to-back words with valid held
        en = 0; tick(); en = 1;
        xfers = 0; uf_cnt = 0; data_valid = 1;
        for (int i = 0; i < 2 * W; i++) begin
            data_in = (i < W) ? 10'h3FF : 10'h000;
            tick();
        end
        chk("t2_xfers", xfers, 2);
        chk("t2_underflows", uf_cnt, 0);

        // 3: underflow frames
        data_valid = 0; uf_cnt = 0;
        ticks(3 * W);
        chk("t3_underflows", uf_cnt, 3);

        // 4: PRBS7 straight from reset
        rst = 1; tick(); rst = 0;
        mode = 2'b01; obs.delete();
        ticks(26 * W);
        for (int i = 0; i < 14; i++) chk("t4_prbs_head", obs[i], prbs14[i]);
        run0 = 0; max_run0 = 0;
        foreach (obs[i]) begin
            run0 = obs[i] ? 0 : run0 + 1;
            if (run0 > max_run0) max_run0 = run0;
        end
        chk("t4_max_zero_run", max_run0, 6);

        // 5: clock pattern, switch to data mid-frame
        en = 0; tick(); en = 1;
        mode = 2'b10;
        ticks(W + 4);
        mode = 2'b00; data_valid = 1; data_in = W'($urandom);
        ticks(W + 6);

        // 6: en drop and rst mid-frame, then fresh frames
        en = 0; tick(); en = 1;
        mode = 2'b00; data_in = W'($urandom);
        ticks(6);
        en = 0; tick();
        chk("t6_en_off_serial", serial_out, 1'b0);
        en = 1; ticks(W + 6);
        rst = 1; tick(); rst = 0;
        chk("t6_rst_serial", serial_out, 1'b0);
        ticks(W);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            data_in    = W'($urandom);
            data_valid = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 15) == 0) mode = 2'($urandom);
            if ($urandom_range(0, 40) == 0) en = ~en;
            else if (!en && $urandom_range(0, 3) == 0) en = 1;
            rst = ($urandom_range(0, 150) == 0);
            tick();
        end
        rst = 0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
